// File: rtl/mmio_pkg.sv
// Shared definitions for MMIO routers: FSM states, default miss data and slot decode.
package mmio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  localparam logic [31:0] MISS_DATA_DEF = 32'hFFFF_FFFF;

  typedef struct packed {
    logic       hit;
    logic [3:0] sel;
  } decode_t;

  // Slot index is the window offset divided by the slot size; addresses below base never hit.
  function automatic decode_t decode_slot(input logic [31:0] addr, input logic [31:0] base,
                                          input int shift, input int num);
    logic [31:0] off;
    logic [31:0] idx;
    decode_t     d;
    off   = addr - base;
    idx   = off >> shift;
    d.hit = (addr >= base) && (idx < 32'(num));
    d.sel = idx[3:0];
    return d;
  endfunction

endpackage

// File: rtl/mmio_bus_router.sv
// Single-master to N-slot MMIO router: one transaction in flight, error termination for
// unmapped addresses and slots that never raise ready.
module mmio_bus_router
  import mmio_pkg::*;
#(
  parameter int          NUM_SLAVES = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
  parameter int          SLOT_SHIFT = 4,
  parameter int          TIMEOUT    = 16,
  parameter logic [31:0] MISS_DATA  = MISS_DATA_DEF
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    m_valid,
  output logic                    m_ready,
  input  logic [3:0]              m_wstrb,
  input  logic [31:0]             m_addr,
  input  logic [31:0]             m_wdata,
  output logic [31:0]             m_rdata,
  output logic [NUM_SLAVES-1:0]   s_valid,
  input  logic [NUM_SLAVES-1:0]   s_ready,
  output logic [3:0]              s_wstrb,
  output logic [31:0]             s_addr,
  output logic [31:0]             s_wdata,
  input  logic [32*NUM_SLAVES-1:0] s_rdata,
  output logic                    err_pulse,
  output logic [31:0]             err_addr,
  output logic [7:0]              err_count
);

  state_t                  r_state;
  logic                    r_m_ready;
  logic [31:0]             r_m_rdata;
  logic [NUM_SLAVES-1:0]   r_s_valid;
  logic [3:0]              r_s_wstrb;
  logic [31:0]             r_s_addr;
  logic [31:0]             r_s_wdata;
  logic [7:0]              r_cnt;
  logic                    r_err_pulse;
  logic [31:0]             r_err_addr;
  logic [7:0]              r_err_count;

  decode_t                 w_dec;
  logic [NUM_SLAVES-1:0]   w_onehot;
  logic                    w_sel_ready;
  logic [31:0]             w_sel_rdata;

  always_comb begin
    w_dec    = decode_slot(m_addr, BASE_ADDR, SLOT_SHIFT, NUM_SLAVES);
    w_onehot = '0;
    for (int k = 0; k < NUM_SLAVES; k++) w_onehot[k] = (w_dec.sel == 4'(k));
  end

  // The one-hot s_valid register doubles as the stored slot selection.
  always_comb begin
    w_sel_ready = |(s_ready & r_s_valid);
    w_sel_rdata = '0;
    for (int k = 0; k < NUM_SLAVES; k++)
      if (r_s_valid[k]) w_sel_rdata = s_rdata[32*k +: 32];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_m_ready   <= 1'b0;
      r_m_rdata   <= '0;
      r_s_valid   <= '0;
      r_s_wstrb   <= '0;
      r_s_addr    <= '0;
      r_s_wdata   <= '0;
      r_cnt       <= '0;
      r_err_pulse <= 1'b0;
      r_err_addr  <= '0;
      r_err_count <= '0;
    end else begin
      r_err_pulse <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (m_valid) begin
            r_s_addr  <= m_addr;
            r_s_wdata <= m_wdata;
            r_s_wstrb <= m_wstrb;
            if (w_dec.hit) begin
              r_s_valid <= w_onehot;
              r_cnt     <= '0;
              r_state   <= ST_ACTIVE;
            end else begin
              r_m_ready   <= 1'b1;
              r_m_rdata   <= MISS_DATA;
              r_err_pulse <= 1'b1;
              r_err_addr  <= m_addr;
              if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
              r_state     <= ST_GAP;
            end
          end
        end
        ST_ACTIVE: begin
          if (w_sel_ready) begin
            r_m_ready <= 1'b1;
            r_m_rdata <= w_sel_rdata;
            r_s_valid <= '0;
            r_state   <= ST_GAP;
          end else if (r_cnt == 8'(TIMEOUT - 1)) begin
            r_s_valid   <= '0;
            r_m_ready   <= 1'b1;
            r_m_rdata   <= MISS_DATA;
            r_err_pulse <= 1'b1;
            r_err_addr  <= r_s_addr;
            if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
            r_state     <= ST_GAP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        // One dead cycle absorbs stale slave ready and a master still holding valid.
        ST_GAP: begin
          r_m_ready <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign m_ready   = r_m_ready;
  assign m_rdata   = r_m_rdata;
  assign s_valid   = r_s_valid;
  assign s_wstrb   = r_s_wstrb;
  assign s_addr    = r_s_addr;
  assign s_wdata   = r_s_wdata;
  assign err_pulse = r_err_pulse;
  assign err_addr  = r_err_addr;
  assign err_count = r_err_count;

endmodule

// File: doc/mmio_bus_router.md
Name: mmio_bus_router

Overview:
- Single-master to N-slave router between the CPU native memory port (valid/ready/wstrb/addr/wdata/rdata) and the register-mapped peripheral slots, such as the GPIO read and write blocks.
- Decodes the address window, forwards one transaction at a time to the selected slot, and returns that slot's read data.
- Terminates unmapped or unresponsive accesses with an error response, so the CPU never hangs.

Parameters:
- NUM_SLAVES, 4, number of peripheral slots (1..16).
- BASE_ADDR, 32'h0300_0000, start of the peripheral window.
- SLOT_SHIFT, 4, log2 of bytes per slot (16 B = 4 registers per slot).
- TIMEOUT, 16, cycles to wait for a slave ready before aborting (2..255).
- MISS_DATA, 32'hFFFF_FFFF, read data returned on error.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- m_valid  in  1  master request.
- m_ready  out  1  one-cycle completion pulse to master.
- m_wstrb  in  4  byte write strobes; 0 = read.
- m_addr  in  32  byte address.
- m_wdata  in  32  write data.
- m_rdata  out  32  read data, valid while m_ready = 1.
- s_valid  out  NUM_SLAVES  one-hot request per slot.
- s_ready  in  NUM_SLAVES  per-slot ready.
- s_wstrb  out  4  registered copy of m_wstrb, shared by all slots.
- s_addr  out  32  registered copy of m_addr, shared.
- s_wdata  out  32  registered copy of m_wdata, shared.
- s_rdata  in  32*NUM_SLAVES  slot k read data at bits [32k+31:32k].
- err_pulse  out  1  one-cycle pulse per aborted transaction.
- err_addr  out  32  address of the most recent error.
- err_count  out  8  saturating error counter.

Behaviour:
- Reset (resetn = 0 at a clk edge):
  - state = IDLE.
  - s_valid = 0, m_ready = 0, m_rdata = 0, s_wstrb/s_addr/s_wdata = 0.
  - err_pulse = 0, err_addr = 0, err_count = 0.
  - Reset mid-transaction drops s_valid immediately; the aborted transaction gets no m_ready.
- States: IDLE, ACTIVE, GAP. All outputs are registered.
- Decode:
  - off = m_addr - BASE_ADDR.
  - Hit iff m_addr >= BASE_ADDR and (off >> SLOT_SHIFT) < NUM_SLAVES.
  - sel = off >> SLOT_SHIFT.
- IDLE, on m_valid = 1:
  - Latch addr, wdata and wstrb into s_*.
  - Hit: s_valid[sel] <= 1, store sel, clear timeout counter, go to ACTIVE.
  - Miss: m_ready <= 1, m_rdata <= MISS_DATA, error event, go to GAP. No s_valid is raised, and writes are dropped.
- ACTIVE:
  - s_ready[sel] = 1: m_ready <= 1, m_rdata <= s_rdata[sel], s_valid <= 0, go to GAP.
  - Otherwise, if the counter has reached TIMEOUT-1: s_valid <= 0, m_ready <= 1, m_rdata <= MISS_DATA, error event, go to GAP.
  - Otherwise increment the counter.
  - s_ready bits of non-selected slots are ignored.
- GAP (exactly one cycle):
  - m_ready <= 0, go to IDLE.
  - s_ready and m_valid are ignored.
  - This covers slaves whose ready is a registered copy of valid (ready stays high one cycle after valid drops) and masters that drop valid the cycle after seeing ready.
- m_ready is high for exactly one cycle per accepted transaction, and never in consecutive cycles.
- Latency for a slave that registers ready one cycle after valid:
  - accept edge E0 → s_valid high after E0.
  - slave ready after E1.
  - m_ready high between E2 and E3.
  - Minimum request spacing is 4 cycles.
- Error event, in the same cycle as the corresponding m_ready:
  - err_pulse <= 1 for one cycle.
  - err_addr <= latched address.
  - err_count <= err_count + 1, saturating at 255.
- s_addr, s_wdata and s_wstrb hold stable from accept until the next accept.
- Master changes to m_addr, m_wdata or m_wstrb during ACTIVE have no effect.

Decomposition:
- Shared package mmio_pkg holds:
  - state enum {IDLE, ACTIVE, GAP};
  - MISS_DATA default constant;
  - a pure function for slot decode (returns hit and sel), reused by future routers.
- No sub-module: the decode is a function and the timeout counter is inline.

Test Plan:
- Read hit, default parameters:
  - m_addr = 0x0300_0014, wstrb = 0, slave 1 model (ready <= valid) with s_rdata[1] = 0x0000_0001.
  - Expect s_valid = 4'b0010 and s_addr = 0x0300_0014.
  - Expect m_ready one cycle, 2 edges after accept, with m_rdata = 0x0000_0001; err_pulse stays 0.
- Write hit:
  - m_addr = 0x0300_0030, wstrb = 4'b0001, wdata = 1.
  - Expect s_valid = 4'b1000, s_wdata = 1, s_wstrb = 1, and a single m_ready pulse.
  - A stale s_ready[3] during GAP does not produce a second m_ready.
- Unmapped accesses:
  - m_addr = 0x0300_0040 (sel = 4) and m_addr = 0x02FF_FFFC.
  - Each: s_valid stays 0, m_ready one edge after accept, m_rdata = 0xFFFF_FFFF, err_pulse = 1.
  - Afterwards err_count = 2 and err_addr = 0x02FF_FFFC.
- Timeout: slot 2 s_ready tied 0.
  - Expect s_valid[2] high for 16 cycles, then low.
  - Expect m_ready with m_rdata = 0xFFFF_FFFF and err_pulse = 1.
- Back-to-back:
  - Master re-asserts m_valid the cycle after m_ready, targeting slot 0 then slot 1.
  - Both complete in order with correct data and no overlap of s_valid bits.
- Reset mid-ACTIVE:
  - Assert resetn = 0 while s_valid[0] = 1.
  - Next cycle s_valid = 0 and m_ready = 0; all err outputs read 0 and no m_ready follows.
  - A later read completes normally.
